usb2_ep_sched: RTL
==================

Name: usb2_ep_sched

Overview:
Endpoint scheduler between the USB 2.0 protocol layer and up to NUM_EP endpoint buffer instances. It decodes each token's endpoint number and drives that endpoint's xfer_in/xfer_out/xfer_out_ok strobes. It also owns per-endpoint data-toggle state and decides the handshake or data PID the protocol layer sends. It provides the endpoint select that steers the shared buffer address/data muxes.

Parameters:
NUM_EP, 4, number of endpoints served (1..16); endpoint 0 is always control.
DATA_TIMEOUT, 96, phy_clk cycles allowed from an OUT/SETUP token to data_done.
HS_TIMEOUT, 96, phy_clk cycles allowed from data send to a host handshake.

Ports:
phy_clk  in  1  clock, all logic rising-edge.
reset_n  in  1  asynchronous active-low reset.
tok_valid  in  1  one-cycle pulse: token decoded with good CRC5.
tok_pid  in  4  token PID (OUT=E, IN=6, SOF=A, SETUP=2, PING=B).
tok_ep  in  4  token endpoint number.
data_done  in  1  pulse: end of host data packet.
data_ok  in  1  valid with data_done: CRC16 good.
data_pid  in  4  valid with data_done: DATA0=C / DATA1=4.
hs_valid  in  1  pulse: host handshake received.
hs_pid  in  4  valid with hs_valid.
ep_xfer_ready  in  NUM_EP  per-endpoint "has IN data / can accept OUT".
ep_stall  in  NUM_EP  per-endpoint halt, from config logic.
toggle_clr  in  NUM_EP  pulse: force endpoint toggle to DATA0.
ep_xfer_in  out  NUM_EP  one-hot level: host data flowing into endpoint.
ep_xfer_out  out  NUM_EP  one-hot level: endpoint data being sent.
ep_xfer_out_ok  out  NUM_EP  one-hot pulse: host ACKed sent data.
ep_rx_drop  out  NUM_EP  one-hot pulse: received packet must be discarded.
ep_sel  out  4  index of the active endpoint, for buffer muxing.
resp_valid  out  1  one-cycle pulse: send resp_pid.
resp_pid  out  4  ACK=D, NAK=5, STALL=1, DATA0=C, DATA1=4.
busy  out  1  high whenever the FSM is not in ST_IDLE.

Behaviour:
- Reset (async assert, sync release): every output is 0; all toggles are 0 (DATA0); FSM enters ST_IDLE.
- FSM states: ST_IDLE, ST_RX_DATA, ST_TX_DATA, ST_RESP.
- ST_IDLE:
  - tok_valid with tok_ep >= NUM_EP, tok_pid=SOF, or an unknown PID: ignored, no response.
  - Otherwise ep_sel <= tok_ep; ep_stall, ep_xfer_ready and the toggle bit are sampled in this same cycle.
- SETUP (endpoint 0 only; SETUP to other endpoints is ignored):
  - Clears ep0's toggle and overrides stall.
  - Asserts ep_xfer_in[0] next cycle and goes to ST_RX_DATA.
- OUT:
  - If stall: resp STALL.
  - Else if !ready: resp NAK; ep_xfer_in stays 0; the data packet is still awaited and then discarded.
  - Else: ep_xfer_in[ep]=1, go to ST_RX_DATA.
- ST_RX_DATA, on data_done:
  - data_ok=0: no response; ep_rx_drop pulse; back to ST_IDLE.
  - data_pid equals the toggle: resp ACK; toggle flips.
  - data_pid differs from the toggle: resp ACK; toggle unchanged; ep_rx_drop pulse.
  - A SETUP packet must be DATA0, otherwise it is treated as data_ok=0.
  - ep_xfer_in drops the cycle after data_done.
- ST_RX_DATA with no data_done after DATA_TIMEOUT cycles: ep_xfer_in drops; ep_rx_drop pulse; ST_IDLE; no response.
- IN:
  - If stall: resp STALL.
  - Else if !ready: resp NAK.
  - Else: resp_pid = DATA0/DATA1 per toggle; ep_xfer_out[ep]=1; go to ST_TX_DATA.
- ST_TX_DATA:
  - hs_valid with hs_pid=ACK: toggle flips; ep_xfer_out_ok pulse; ep_xfer_out drops; ST_IDLE.
  - Any other hs_pid, or HS_TIMEOUT expiry: ep_xfer_out drops; toggle unchanged; no ok pulse; ST_IDLE. The same data is resent on the next IN.
- PING: stall gives STALL; ready gives ACK; otherwise NAK. Toggle is untouched.
- Latency:
  - resp_valid asserts exactly 2 cycles after tok_valid for IN/PING/NAK/STALL cases.
  - resp_valid asserts 2 cycles after data_done for OUT/SETUP ACK.
  - ST_RESP lasts one cycle, then returns to ST_IDLE.
- tok_valid while busy: ignored, no state change.
- Simultaneous toggle_clr and toggle flip on the same endpoint: clear wins (result 0).
- ep_stall changing mid-transaction does not affect the current transaction.
- Timeout counters are 8-bit, cleared on state entry, and saturate.

Decomposition:
- Shared package usb2_pkg: PID constants (token, data, handshake), FSM state encodings, and the ep index width function.
- One sub-module, usb2_ep_toggle: NUM_EP-bit toggle register file with indexed read, flip and clear ports, and clear-over-flip priority.

Test Plan:
- Reset, then IN ep1 with ready=1 and toggle 0 -> resp DATA0 at +2 cycles, ep_xfer_out=0010. Host ACK -> ep_xfer_out_ok[1] pulse; next IN gives DATA1.
- OUT ep2, data DATA0, data_ok=1 -> ACK, toggle[2]=1. Repeat with DATA0 -> ACK plus ep_rx_drop[2], toggle stays 1.
- SETUP ep0 with ep_stall[0]=1 and toggle[0]=1 -> accepted; DATA0 good -> ACK; toggle[0]=1 after.
- IN ep3 with ep_stall[3]=1 -> STALL. IN ep1 with ready=0 -> NAK. Token ep=7 with NUM_EP=4 -> no resp_valid.
- IN ep1 with no handshake for 96 cycles -> ep_xfer_out drops, no ok pulse; the retry resends the same DATAx.
- toggle_clr[1] asserted in the same cycle as ACK-driven flip of toggle[1] -> toggle[1]=0. A mid-OUT reset_n assert clears all outputs asynchronously.

Source files
------------

// File: rtl/usb2_pkg.sv
// Shared USB 2.0 definitions: PID codes, endpoint scheduler FSM states and
// endpoint index width helper.
package usb2_pkg;

  localparam logic [3:0] PID_OUT   = 4'hE;
  localparam logic [3:0] PID_IN    = 4'h6;
  localparam logic [3:0] PID_SOF   = 4'hA;
  localparam logic [3:0] PID_SETUP = 4'h2;
  localparam logic [3:0] PID_PING  = 4'hB;
  localparam logic [3:0] PID_DATA0 = 4'hC;
  localparam logic [3:0] PID_DATA1 = 4'h4;
  localparam logic [3:0] PID_ACK   = 4'hD;
  localparam logic [3:0] PID_NAK   = 4'h5;
  localparam logic [3:0] PID_STALL = 4'h1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX_DATA,
    ST_TX_DATA,
    ST_RESP
  } state_t;

  function automatic int ep_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/usb2_ep_toggle.sv
// Per-endpoint data-toggle bits with indexed read, indexed flip and
// per-endpoint clear; a clear beats a flip on the same endpoint.
module usb2_ep_toggle
  import usb2_pkg::*;
#(
  parameter int NUM_EP = 4
) (
  input  logic                          phy_clk,
  input  logic                          reset_n,
  input  logic [ep_idx_w(NUM_EP)-1:0]   rd_idx,
  output logic                          rd_bit,
  input  logic                          flip_en,
  input  logic [ep_idx_w(NUM_EP)-1:0]   flip_idx,
  input  logic [NUM_EP-1:0]             clr
);

  logic [NUM_EP-1:0] tog;

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      tog <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_EP; i++) begin
        if (clr[i])
          tog[i] <= 1'b0;
        else if (flip_en && (32'(flip_idx) == i))
          tog[i] <= ~tog[i];
      end
    end
  end

  assign rd_bit = tog[rd_idx];

endmodule

// File: rtl/usb2_ep_sched.sv
// USB 2.0 endpoint scheduler: routes tokens to endpoint strobes, tracks data
// toggles and chooses the handshake/data PID returned to the host.
module usb2_ep_sched
  import usb2_pkg::*;
#(
  parameter int NUM_EP       = 4,
  parameter int DATA_TIMEOUT = 96,
  parameter int HS_TIMEOUT   = 96
) (
  input  logic              phy_clk,
  input  logic              reset_n,
  input  logic              tok_valid,
  input  logic [3:0]        tok_pid,
  input  logic [3:0]        tok_ep,
  input  logic              data_done,
  input  logic              data_ok,
  input  logic [3:0]        data_pid,
  input  logic              hs_valid,
  input  logic [3:0]        hs_pid,
  input  logic [NUM_EP-1:0] ep_xfer_ready,
  input  logic [NUM_EP-1:0] ep_stall,
  input  logic [NUM_EP-1:0] toggle_clr,
  output logic [NUM_EP-1:0] ep_xfer_in,
  output logic [NUM_EP-1:0] ep_xfer_out,
  output logic [NUM_EP-1:0] ep_xfer_out_ok,
  output logic [NUM_EP-1:0] ep_rx_drop,
  output logic [3:0]        ep_sel,
  output logic              resp_valid,
  output logic [3:0]        resp_pid,
  output logic              busy
);

  localparam int EW = ep_idx_w(NUM_EP);
  localparam logic [7:0] DATA_LIM = 8'(DATA_TIMEOUT - 1);
  localparam logic [7:0] HS_LIM   = 8'(HS_TIMEOUT - 1);

  state_t            state, nxt_state;
  logic [3:0]        nxt_sel;
  logic              cur_tog, nxt_tog;
  logic              cur_setup, nxt_setup;
  logic              cur_nak, nxt_nak;
  logic [7:0]        tmr, nxt_tmr;
  logic              arm, nxt_arm;
  logic [3:0]        arm_pid, nxt_arm_pid;
  logic [NUM_EP-1:0] nxt_xin, nxt_xout, nxt_ok, nxt_drop;
  logic              flip_en, setup_clr, tog_rd, tok_hit, data_good;
  logic [NUM_EP-1:0] tok_oh, sel_oh, clr_all;
  logic [3:0]        exp_data;

  assign tok_hit  = tok_valid && ({28'd0, tok_ep} < 32'(NUM_EP));
  assign tok_oh   = NUM_EP'(1) << tok_ep;
  assign sel_oh   = NUM_EP'(1) << ep_sel;
  assign exp_data = cur_tog ? PID_DATA1 : PID_DATA0;
  // A SETUP payload that is not DATA0 is handled exactly like a CRC failure.
  assign data_good = data_ok && !(cur_setup && (data_pid != PID_DATA0));
  assign busy     = (state != ST_IDLE);

  always_comb begin
    clr_all    = toggle_clr;
    clr_all[0] = toggle_clr[0] | setup_clr;
  end

  usb2_ep_toggle #(.NUM_EP(NUM_EP)) u_toggle (
    .phy_clk  (phy_clk),
    .reset_n  (reset_n),
    .rd_idx   (tok_ep[EW-1:0]),
    .rd_bit   (tog_rd),
    .flip_en  (flip_en),
    .flip_idx (ep_sel[EW-1:0]),
    .clr      (clr_all)
  );

  always_comb begin
    nxt_state   = state;
    nxt_sel     = ep_sel;
    nxt_tog     = cur_tog;
    nxt_setup   = cur_setup;
    nxt_nak     = cur_nak;
    nxt_tmr     = (tmr == 8'hFF) ? tmr : tmr + 8'd1;
    nxt_arm     = 1'b0;
    nxt_arm_pid = arm_pid;
    nxt_xin     = ep_xfer_in;
    nxt_xout    = ep_xfer_out;
    nxt_ok      = '0;
    nxt_drop    = '0;
    flip_en     = 1'b0;
    setup_clr   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (tok_hit) begin
          case (tok_pid)
            PID_SETUP: if (tok_ep == 4'd0) begin
              nxt_sel   = tok_ep;
              setup_clr = 1'b1;
              nxt_tog   = 1'b0;
              nxt_setup = 1'b1;
              nxt_nak   = 1'b0;
              nxt_xin   = tok_oh;
              nxt_state = ST_RX_DATA;
            end
            PID_OUT: begin
              nxt_sel   = tok_ep;
              nxt_tog   = tog_rd;
              nxt_setup = 1'b0;
              nxt_nak   = 1'b0;
              if (ep_stall[tok_ep[EW-1:0]]) begin
                {nxt_arm, nxt_arm_pid} = {1'b1, PID_STALL};
                nxt_state = ST_RESP;
              end else if (!ep_xfer_ready[tok_ep[EW-1:0]]) begin
                // NAK goes out now; the data packet is still swallowed in RX.
                {nxt_arm, nxt_arm_pid} = {1'b1, PID_NAK};
                nxt_nak   = 1'b1;
                nxt_state = ST_RX_DATA;
              end else begin
                nxt_xin   = tok_oh;
                nxt_state = ST_RX_DATA;
              end
            end
            PID_IN: begin
              nxt_sel   = tok_ep;
              nxt_state = ST_RESP;
              if (ep_stall[tok_ep[EW-1:0]]) begin
                {nxt_arm, nxt_arm_pid} = {1'b1, PID_STALL};
              end else if (!ep_xfer_ready[tok_ep[EW-1:0]]) begin
                {nxt_arm, nxt_arm_pid} = {1'b1, PID_NAK};
              end else begin
                {nxt_arm, nxt_arm_pid} = {1'b1, tog_rd ? PID_DATA1 : PID_DATA0};
                nxt_xout  = tok_oh;
                nxt_state = ST_TX_DATA;
              end
            end
            PID_PING: begin
              nxt_sel   = tok_ep;
              nxt_arm   = 1'b1;
              nxt_state = ST_RESP;
              if (ep_stall[tok_ep[EW-1:0]])           nxt_arm_pid = PID_STALL;
              else if (ep_xfer_ready[tok_ep[EW-1:0]]) nxt_arm_pid = PID_ACK;
              else                                    nxt_arm_pid = PID_NAK;
            end
            default: ;
          endcase
        end
      end
      ST_RX_DATA: begin
        if (data_done) begin
          nxt_xin   = '0;
          nxt_state = ST_IDLE;
          if (cur_nak || !data_good) begin
            nxt_drop = sel_oh;
          end else begin
            {nxt_arm, nxt_arm_pid} = {1'b1, PID_ACK};
            nxt_state = ST_RESP;
            if (data_pid == exp_data) flip_en  = 1'b1;
            else                      nxt_drop = sel_oh;
          end
        end else if (tmr >= DATA_LIM) begin
          nxt_xin   = '0;
          nxt_drop  = sel_oh;
          nxt_state = ST_IDLE;
        end
      end
      ST_TX_DATA: begin
        if (hs_valid) begin
          nxt_xout  = '0;
          nxt_state = ST_IDLE;
          if (hs_pid == PID_ACK) begin
            flip_en = 1'b1;
            nxt_ok  = sel_oh;
          end
        end else if (tmr >= HS_LIM) begin
          nxt_xout  = '0;
          nxt_state = ST_IDLE;
        end
      end
      ST_RESP: nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase

    if (nxt_state != state) nxt_tmr = '0;
  end

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      ep_sel         <= '0;
      cur_tog        <= 1'b0;
      cur_setup      <= 1'b0;
      cur_nak        <= 1'b0;
      tmr            <= '0;
      arm            <= 1'b0;
      arm_pid        <= '0;
      ep_xfer_in     <= '0;
      ep_xfer_out    <= '0;
      ep_xfer_out_ok <= '0;
      ep_rx_drop     <= '0;
      resp_valid     <= 1'b0;
      resp_pid       <= '0;
    end else begin
      state          <= nxt_state;
      ep_sel         <= nxt_sel;
      cur_tog        <= nxt_tog;
      cur_setup      <= nxt_setup;
      cur_nak        <= nxt_nak;
      tmr            <= nxt_tmr;
      arm            <= nxt_arm;
      arm_pid        <= nxt_arm_pid;
      ep_xfer_in     <= nxt_xin;
      ep_xfer_out    <= nxt_xout;
      ep_xfer_out_ok <= nxt_ok;
      ep_rx_drop     <= nxt_drop;
      resp_valid     <= arm;
      resp_pid       <= arm ? arm_pid : 4'h0;
    end
  end

endmodule
